cmp_vector_gen: RTL and testbench

Hardware stimulus source for the magnitude-comparator blocks. It sweeps every operand pair `{a, b}` of width `WIDTH`, first in unsigned (binary) mode and then in two's-complement mode. For each pair it computes the golden `EQ`/`GT` result and streams `{a, b, eq, gt, mode}` vectors over a valid/ready interface. It is the writing end of the comparator vector stream and feeds both the on-chip checkers and the vector-dump benches.

---
 rtl/cmp_vec_pkg.sv | 37 +++
 rtl/cmp_ref_model.sv | 27 ++
 rtl/cmp_vector_gen.sv | 159 +++++++++++++++
 tb/tb_cmp_vector_gen.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_vec_pkg.sv
// Shared types and the golden comparison function for the comparator
// vector generator.
package cmp_vec_pkg;

   // Sweep sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN_U = 2'd1,
      RUN_S = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Comparison mode encodings carried on out_tcs
   localparam logic MODE_UNSIGNED = 1'b0;
   localparam logic MODE_TCS      = 1'b1;

   // Widest operand the generator supports
   localparam int MAX_WIDTH = 12;

   // Golden compare on MAX_WIDTH operands; returns {eq, gt}.
   // Narrower operands must be left-justified by the caller so that the
   // sign bit sits in the MSB; left-justification preserves both the
   // unsigned and the signed ordering.
   function automatic logic [1:0] golden_cmp(input logic [MAX_WIDTH-1:0] a,
                                             input logic [MAX_WIDTH-1:0] b,
                                             input logic                 tcs);
      logic eq;
      logic gt;
      eq = (a == b);
      if (tcs == MODE_TCS)
         gt = ($signed(a) > $signed(b));
      else
         gt = (a > b);
      return {eq, gt};
   endfunction

endpackage

// File: rtl/cmp_ref_model.sv
// Combinational golden EQ/GT for one operand pair of a given width.
module cmp_ref_model
   import cmp_vec_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             tcs,
   output logic             eq,
   output logic             gt
);

   logic [MAX_WIDTH-1:0] a_al;
   logic [MAX_WIDTH-1:0] b_al;
   logic [1:0]           res;

   // Left-justify so the operand sign bit lands in the function's MSB
   assign a_al = MAX_WIDTH'(a) << (MAX_WIDTH - WIDTH);
   assign b_al = MAX_WIDTH'(b) << (MAX_WIDTH - WIDTH);

   // Evaluate golden result for the selected mode
   assign res = golden_cmp(a_al, b_al, tcs);
   assign eq  = res[1];
   assign gt  = res[0];

endmodule

// File: rtl/cmp_vector_gen.sv
// Comparator stimulus source: sweeps every {a, b} pair, first unsigned then
// two's-complement, streaming {a, b, eq, gt, tcs} over valid/ready.
// vec_count is 2*WIDTH+2 bits wide: the final count 2^(2*WIDTH+1) needs
// one bit more than 2*WIDTH+1 to be representable.
module cmp_vector_gen
   import cmp_vec_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_a,
   output logic [WIDTH-1:0]   out_b,
   output logic               out_eq,
   output logic               out_gt,
   output logic               out_tcs,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH+1:0] vec_count
);

   localparam int SW = 2 * WIDTH;
   localparam int CW = 2 * WIDTH + 2;

   localparam logic [SW-1:0] SWEEP_ONE = {{(SW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] COUNT_ONE = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] COUNT_MAX = COUNT_ONE << (SW + 1);

   state_t            state_reg;
   logic [SW-1:0]     sweep_reg;
   logic              out_valid_reg;
   logic [WIDTH-1:0]  out_a_reg;
   logic [WIDTH-1:0]  out_b_reg;
   logic              out_eq_reg;
   logic              out_gt_reg;
   logic              out_tcs_reg;
   logic              busy_reg;
   logic              done_reg;
   logic [CW-1:0]     vec_count_reg;

   logic              handshake;
   logic              sweep_last;
   logic [SW-1:0]     sweep_next;
   logic [SW-1:0]     sel_cnt;
   logic              sel_tcs;
   logic              ref_eq;
   logic              ref_gt;
   logic [CW-1:0]     count_inc;

   assign handshake  = out_valid_reg & out_ready;
   assign sweep_last = &sweep_reg;
   assign sweep_next = sweep_reg + SWEEP_ONE;
   assign count_inc  = (vec_count_reg == COUNT_MAX) ? vec_count_reg
                                                    : vec_count_reg + COUNT_ONE;

   // Select the vector that will be presented after the next load:
   // the first vector when idle/done, otherwise the successor of the current one
   always_comb begin
      sel_cnt = '0;
      sel_tcs = MODE_UNSIGNED;
      if (state_reg == RUN_U) begin
         sel_cnt = sweep_next;
         sel_tcs = sweep_last ? MODE_TCS : MODE_UNSIGNED;
      end else if (state_reg == RUN_S) begin
         sel_cnt = sweep_next;
         sel_tcs = MODE_TCS;
      end
   end

   cmp_ref_model #(
      .WIDTH (WIDTH)
   ) u_ref (
      .a   (sel_cnt[SW-1:WIDTH]),
      .b   (sel_cnt[WIDTH-1:0]),
      .tcs (sel_tcs),
      .eq  (ref_eq),
      .gt  (ref_gt)
   );

   // Sequencer, sweep counter, output register stage and accepted-vector count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         sweep_reg     <= '0;
         out_valid_reg <= 1'b0;
         out_a_reg     <= '0;
         out_b_reg     <= '0;
         out_eq_reg    <= 1'b0;
         out_gt_reg    <= 1'b0;
         out_tcs_reg   <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         vec_count_reg <= '0;
      end else if (abort) begin
         state_reg     <= IDLE;
         sweep_reg     <= '0;
         out_valid_reg <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         vec_count_reg <= '0;
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               if (state_reg == IDLE)
                  vec_count_reg <= '0;
               if (start) begin
                  state_reg     <= RUN_U;
                  sweep_reg     <= '0;
                  out_valid_reg <= 1'b1;
                  out_a_reg     <= sel_cnt[SW-1:WIDTH];
                  out_b_reg     <= sel_cnt[WIDTH-1:0];
                  out_eq_reg    <= ref_eq;
                  out_gt_reg    <= ref_gt;
                  out_tcs_reg   <= sel_tcs;
                  busy_reg      <= 1'b1;
                  done_reg      <= 1'b0;
                  vec_count_reg <= '0;
               end
            end
            RUN_U, RUN_S: begin
               if (handshake) begin
                  vec_count_reg <= count_inc;
                  if (state_reg == RUN_S && sweep_last) begin
                     state_reg     <= DONE;
                     out_valid_reg <= 1'b0;
                     busy_reg      <= 1'b0;
                     done_reg      <= 1'b1;
                  end else begin
                     if (sweep_last)
                        state_reg <= RUN_S;
                     sweep_reg   <= sweep_next;
                     out_a_reg   <= sel_cnt[SW-1:WIDTH];
                     out_b_reg   <= sel_cnt[WIDTH-1:0];
                     out_eq_reg  <= ref_eq;
                     out_gt_reg  <= ref_gt;
                     out_tcs_reg <= sel_tcs;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign out_valid = out_valid_reg;
   assign out_a     = out_a_reg;
   assign out_b     = out_b_reg;
   assign out_eq    = out_eq_reg;
   assign out_gt    = out_gt_reg;
   assign out_tcs   = out_tcs_reg;
   assign busy      = busy_reg;
   assign done      = done_reg;
   assign vec_count = vec_count_reg;

endmodule

// File: tb/tb_cmp_vector_gen.sv
// Directed bench for cmp_vector_gen at WIDTH=4 (512-vector full sweep).
module tb_cmp_vector_gen;

   localparam int W  = 4;
   localparam int CW = 2 * W + 2;

   logic          clk;
   logic          reset;
   logic          start;
   logic          abort;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_a;
   logic [W-1:0]  out_b;
   logic          out_eq;
   logic          out_gt;
   logic          out_tcs;
   logic          busy;
   logic          done;
   logic [CW-1:0] vec_count;

   int errors = 0;
   int checks = 0;

   cmp_vector_gen #(
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_eq    (out_eq),
      .out_gt    (out_gt),
      .out_tcs   (out_tcs),
      .busy      (busy),
      .done      (done),
      .vec_count (vec_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle just after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      tick(); tick();
      checks++;
      if ({out_valid, out_a, out_b, out_eq, out_gt, out_tcs, busy, done, vec_count} !== '0) begin
         errors++;
         $display("FAIL reset_values: got valid=%b a=%h b=%h eq=%b gt=%b tcs=%b busy=%b done=%b cnt=%0d, want all zero",
                  out_valid, out_a, out_b, out_eq, out_gt, out_tcs, busy, done, vec_count);
      end
      reset = 1'b0;
      tick(); tick();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_start: got valid=%b busy=%b, want 0 0", out_valid, busy);
      end
      $display("test_reset done");
   endtask

   task automatic test_first_vector(input string name);
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if ({out_valid, out_a, out_b, out_eq, out_gt, out_tcs, busy, done} !== {1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}
          || vec_count !== 10'd0) begin
         errors++;
         $display("FAIL %s: got valid=%b a=%h b=%h eq=%b gt=%b tcs=%b busy=%b done=%b cnt=%0d, want 1 0 0 1 0 0 1 0 0",
                  name, out_valid, out_a, out_b, out_eq, out_gt, out_tcs, busy, done, vec_count);
      end
      $display("%s: a=%h b=%h eq=%b gt=%b tcs=%b", name, out_a, out_b, out_eq, out_gt, out_tcs);
   endtask

   task automatic test_full_sweep();
      logic [8:0] idx;
      logic [W-1:0] ea;
      logic [W-1:0] eb;
      logic et, ee, eg;
      out_ready = 1'b1;
      for (int i = 0; i < 512; i++) begin
         idx = i[8:0];
         et  = idx[8];
         ea  = idx[7:4];
         eb  = idx[3:0];
         ee  = (ea == eb);
         eg  = et ? ($signed(ea) > $signed(eb)) : (ea > eb);
         // start held during the run must be ignored
         start = (i >= 100 && i < 110);
         checks++;
         if ({out_valid, out_a, out_b, out_eq, out_gt, out_tcs, busy, done} !== {1'b1, ea, eb, ee, eg, et, 1'b1, 1'b0}
             || vec_count !== CW'(i)) begin
            errors++;
            $display("FAIL sweep_vec[%0d]: got valid=%b a=%h b=%h eq=%b gt=%b tcs=%b busy=%b done=%b cnt=%0d, want 1 %h %h %b %b %b 1 0 %0d",
                     i, out_valid, out_a, out_b, out_eq, out_gt, out_tcs, busy, done, vec_count, ea, eb, ee, eg, et, i);
         end
         // Hand-computed spot vectors
         if (i == 9'h0F1 || i == 9'h1F1 || i == 9'h078 || i == 9'h178) begin
            checks++;
            if ((i == 9'h0F1 && {out_eq, out_gt} !== 2'b01) ||
                (i == 9'h1F1 && {out_eq, out_gt} !== 2'b00) ||
                (i == 9'h078 && {out_eq, out_gt} !== 2'b00) ||
                (i == 9'h178 && {out_eq, out_gt} !== 2'b01)) begin
               errors++;
               $display("FAIL spot_vec[%0h]: got a=%h b=%h eq=%b gt=%b tcs=%b", i, out_a, out_b, out_eq, out_gt, out_tcs);
            end
            $display("spot vector a=%h b=%h tcs=%b eq=%b gt=%b", out_a, out_b, out_tcs, out_eq, out_gt);
         end
         tick();
      end
      start = 1'b0;
      checks++;
      if ({out_valid, busy, done} !== 3'b001 || vec_count !== 10'd512) begin
         errors++;
         $display("FAIL sweep_done: got valid=%b busy=%b done=%b cnt=%0d, want 0 0 1 512",
                  out_valid, busy, done, vec_count);
      end
      $display("test_full_sweep: cnt=%0d done=%b", vec_count, done);
   endtask

   task automatic test_done_hold();
      tick(); tick(); tick();
      checks++;
      if ({out_valid, done} !== 2'b01 || vec_count !== 10'd512) begin
         errors++;
         $display("FAIL done_hold: got valid=%b done=%b cnt=%0d, want 0 1 512", out_valid, done, vec_count);
      end
      $display("test_done_hold: cnt=%0d", vec_count);
   endtask

   task automatic test_backpressure();
      logic [W-1:0] ha;
      logic [W-1:0] hb;
      out_ready = 1'b1;
      for (int i = 0; i < 18; i++) tick();
      checks++;
      if (out_a !== 4'h1 || out_b !== 4'h2 || vec_count !== 10'd18) begin
         errors++;
         $display("FAIL bp_setup: got a=%h b=%h cnt=%0d, want 1 2 18", out_a, out_b, vec_count);
      end
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if ({out_valid, out_a, out_b, out_eq, out_gt, out_tcs} !== {1'b1, 4'h1, 4'h2, 1'b0, 1'b0, 1'b0}
             || vec_count !== 10'd18) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got valid=%b a=%h b=%h eq=%b gt=%b tcs=%b cnt=%0d, want 1 1 2 0 0 0 18",
                     i, out_valid, out_a, out_b, out_eq, out_gt, out_tcs, vec_count);
         end
      end
      out_ready = 1'b1;
      tick();
      ha = out_a; hb = out_b;
      checks++;
      if (ha !== 4'h1 || hb !== 4'h3 || vec_count !== 10'd19) begin
         errors++;
         $display("FAIL bp_release: got a=%h b=%h cnt=%0d, want 1 3 19", ha, hb, vec_count);
      end
      $display("test_backpressure: released to a=%h b=%h", ha, hb);
   endtask

   task automatic test_abort();
      int n;
      n = 0;
      out_ready = 1'b1;
      while (vec_count !== 10'd100 && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (vec_count !== 10'd100) begin
         errors++;
         $display("FAIL abort_reach: got cnt=%0d, want 100 within 200 cycles", vec_count);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if ({out_valid, busy, done} !== 3'b000 || vec_count !== 10'd0) begin
         errors++;
         $display("FAIL abort_clear: got valid=%b busy=%b done=%b cnt=%0d, want 0 0 0 0",
                  out_valid, busy, done, vec_count);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
      checks++;
      if ({out_valid, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL abort_idle: got valid=%b busy=%b done=%b, want 0 0 0", out_valid, busy, done);
      end
      $display("test_abort: aborted after %0d cycles", n);
      out_ready = 1'b0;
      test_first_vector("abort_restart");
   endtask

   task automatic test_reset_mid_run();
      out_ready = 1'b1;
      for (int i = 0; i < 300; i++) tick();
      checks++;
      if ({out_valid, out_tcs, busy} !== 3'b111) begin
         errors++;
         $display("FAIL run_s_reach: got valid=%b tcs=%b busy=%b, want 1 1 1", out_valid, out_tcs, busy);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({out_valid, out_a, out_b, out_eq, out_gt, out_tcs, busy, done, vec_count} !== '0) begin
         errors++;
         $display("FAIL async_reset: got valid=%b a=%h b=%h eq=%b gt=%b tcs=%b busy=%b done=%b cnt=%0d, want all zero",
                  out_valid, out_a, out_b, out_eq, out_gt, out_tcs, busy, done, vec_count);
      end
      reset = 1'b0;
      tick(); tick(); tick();
      checks++;
      if ({out_valid, busy, done} !== 3'b000 || vec_count !== 10'd0) begin
         errors++;
         $display("FAIL no_resume: got valid=%b busy=%b done=%b cnt=%0d, want 0 0 0 0",
                  out_valid, busy, done, vec_count);
      end
      $display("test_reset_mid_run: outputs cleared asynchronously");
      out_ready = 1'b0;
      test_first_vector("reset_restart");
   endtask

   // Watchdog so the run always terminates
   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_first_vector("first_vector");
      test_full_sweep();
      test_done_hold();
      out_ready = 1'b0;
      test_first_vector("done_restart");
      test_backpressure();
      test_abort();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
